// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a double-buffered digit memory.
// Shadow writes reach the displayed buffer only at frame boundaries, so a frame never tears.
module sevenseg_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter int AW           = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [4:0]        wr_data,
  input  logic              commit,
  output logic              commit_pending,
  output logic [6:0]        seg_out,
  output logic [DIGITS-1:0] dig_sel,
  output logic              frame_tick
);
  localparam int DW = $clog2(DIGITS);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(DIGITS - 1);
  localparam logic [4:0]    BLANK_CODE = 5'b1_0000;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;
  localparam state_t FIRST_PH = (BLANK_CYCLES == 0) ? S_SHOW : S_BLANK;

  state_t          state_q, state_d;
  logic [DW-1:0]   digit_q, digit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic            apply;
  logic [4:0]      shadow_q [DIGITS];
  logic [4:0]      shadow_d [DIGITS];
  logic [4:0]      active_q [DIGITS];
  logic [4:0]      active_d [DIGITS];
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] dig_q, dig_d;
  logic              tick_q, tick_d;

  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] s;
    case (code[3:0])
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7C;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h67;
      default: s = 7'h00;
    endcase
    return code[4] ? 7'h00 : s;
  endfunction

  // The slot counter runs 0..PRESCALE-1 across both BLANK and SHOW phases.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = S_IDLE;
      digit_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = FIRST_PH;
          digit_d = '0;
          cnt_d   = '0;
        end
        S_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = S_SHOW;
        end
        S_SHOW: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
            state_d = FIRST_PH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The copy reads the pre-edge shadow, so a write in the frame_tick cycle misses it.
  always_comb begin
    apply    = tick_q & pending_q;
    active_d = active_q;
    if (apply) active_d = shadow_q;
    shadow_d = shadow_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (wr_en && (32'(wr_addr) == i)) shadow_d[i] = wr_data;
    end
    pending_d = commit | (pending_q & ~apply);
  end

  always_comb begin
    seg_d  = '0;
    dig_d  = '0;
    tick_d = 1'b0;
    if (state_d == S_SHOW) begin
      dig_d  = DIGITS'(1) << digit_d;
      seg_d  = decode(active_d[digit_d]);
      tick_d = (cnt_d == CNT_LAST) && (digit_d == DIG_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      digit_q   <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      seg_q     <= '0;
      dig_q     <= '0;
      tick_q    <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        shadow_q[i] <= BLANK_CODE;
        active_q[i] <= BLANK_CODE;
      end
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
      tick_q    <= tick_d;
      for (int i = 0; i < DIGITS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign commit_pending = pending_q;
  assign seg_out        = seg_q;
  assign dig_sel        = dig_q;
  assign frame_tick     = tick_q;

endmodule
